// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with run-time frame format.
//
// Ports:
//   clk         - single clock, all state changes on the rising edge
//   rst         - asynchronous, active-low reset
//   RX_IN       - serial line (idle high, LSB first), already synchronised
//   Prescale    - oversampling clocks per bit (even, 4..2^PRESCALE_W-2)
//   data_len    - data bits per frame (5..MAX_DATA_W)
//   PAR_EN      - parity bit present
//   PAR_TYP     - 0 = even parity, 1 = odd parity
//   two_stop    - 1 = two stop bits expected
//   P_DATA      - last accepted word, zero-extended above data_len
//   data_valid  - one-cycle pulse, P_DATA just updated
//   par_error   - one-cycle pulse, parity mismatch
//   stop_error  - one-cycle pulse, framing error (stop bit sampled low)
//   busy        - high whenever the receiver is not idle
module uart_rx_param #(
  parameter int MAX_DATA_W = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic [3:0]            data_len,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  two_stop,
  output logic [MAX_DATA_W-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_error,
  output logic                  stop_error,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                  state_q;
  logic [PRESCALE_W-1:0]   cnt_q;
  logic [PRESCALE_W-1:0]   presc_q;
  logic [3:0]              len_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic                    two_stop_q;
  logic [3:0]              bit_q;
  logic                    stop2_q;
  logic [2:0]              smp_q;
  logic [MAX_DATA_W-1:0]   shift_q;
  logic                    par_acc_q;
  logic                    perr_q;
  logic [MAX_DATA_W-1:0]   pdata_q;
  logic                    dv_q;
  logic                    pe_q;
  logic                    se_q;
  logic                    busy_q;

  logic [PRESCALE_W-1:0]   half;
  logic                    last_cnt;
  logic                    smp2_eff;
  logic                    vote;
  logic                    final_stop;
  logic                    par_mismatch;
  logic                    start_frame;

  always_comb begin
    half         = presc_q >> 1;
    last_cnt     = (cnt_q == presc_q - 1'b1);
    // With Prescale = 4 the third sample lands on the same count as the
    // vote, so the live line value stands in for the not-yet-stored sample.
    smp2_eff     = (cnt_q == half + 1'b1) ? RX_IN : smp_q[2];
    vote         = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp2_eff) |
                   (smp_q[1] & smp2_eff);
    final_stop   = !two_stop_q || stop2_q;
    par_mismatch = vote ^ par_acc_q ^ par_typ_q;
    // A new frame starts from idle, or straight out of a good final stop
    // bit when the line is already low (back-to-back frames).
    start_frame  = !RX_IN &&
                   ((state_q == S_IDLE) ||
                    (state_q == S_STOP && last_cnt && vote && final_stop));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      presc_q    <= '0;
      len_q      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      two_stop_q <= 1'b0;
      bit_q      <= '0;
      stop2_q    <= 1'b0;
      smp_q      <= '0;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      perr_q     <= 1'b0;
      pdata_q    <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      pe_q <= 1'b0;
      se_q <= 1'b0;

      if (state_q != S_IDLE) begin
        cnt_q <= last_cnt ? '0 : cnt_q + 1'b1;
        if (cnt_q == half - 1'b1) smp_q[0] <= RX_IN;
        if (cnt_q == half)        smp_q[1] <= RX_IN;
        if (cnt_q == half + 1'b1) smp_q[2] <= RX_IN;
      end

      case (state_q)
        S_START: begin
          if (last_cnt) begin
            if (vote) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
              bit_q   <= '0;
            end
          end
        end

        S_DATA: begin
          if (last_cnt) begin
            for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
              if (bit_q == i[3:0]) shift_q[i] <= vote;
            end
            par_acc_q <= par_acc_q ^ vote;
            if (bit_q == len_q - 1'b1) begin
              state_q <= par_en_q ? S_PARITY : S_STOP;
              stop2_q <= 1'b0;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end

        S_PARITY: begin
          if (last_cnt) begin
            if (par_mismatch) begin
              pe_q   <= 1'b1;
              perr_q <= 1'b1;
            end
            state_q <= S_STOP;
          end
        end

        S_STOP: begin
          if (last_cnt) begin
            if (!vote) begin
              se_q    <= 1'b1;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else if (!final_stop) begin
              stop2_q <= 1'b1;
            end else begin
              if (!perr_q) begin
                pdata_q <= shift_q;
                dv_q    <= 1'b1;
              end
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        default: ;
      endcase

      // Overrides the end-of-frame return to idle when a new start is seen.
      if (start_frame) begin
        state_q    <= S_START;
        cnt_q      <= '0;
        presc_q    <= Prescale;
        len_q      <= data_len;
        par_en_q   <= PAR_EN;
        par_typ_q  <= PAR_TYP;
        two_stop_q <= two_stop;
        bit_q      <= '0;
        stop2_q    <= 1'b0;
        shift_q    <= '0;
        par_acc_q  <= 1'b0;
        perr_q     <= 1'b0;
        busy_q     <= 1'b1;
      end
    end
  end

  assign P_DATA     = pdata_q;
  assign data_valid = dv_q;
  assign par_error  = pe_q;
  assign stop_error = se_q;
  assign busy       = busy_q;

endmodule
